// File: rtl/vec3_normalize_seq_pkg.sv
// rtl/vec3_normalize_seq_pkg.sv - shared types, constants and helpers for the vec3 normaliser
package vec3_normalize_seq_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int FRAC_BITS         = 16;
    localparam int DIV_ITERS         = DATA_WIDTH + FRAC_BITS;
    localparam int NORM_LATENCY      = 1 + DATA_WIDTH + 3 * (DIV_ITERS + 1);
    localparam int NORM_ZERO_LATENCY = 1 + DATA_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        SQRT,
        DIVX,
        DIVY,
        DIVZ,
        DONE
    } norm_state_t;

    // Unsigned magnitude; -2^31 maps to 2^31 without overflow.
    function automatic logic [DATA_WIDTH-1:0] abs_mag(input fp v);
        return v[DATA_WIDTH-1] ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
    endfunction

    function automatic fp apply_sign(input logic [DATA_WIDTH-1:0] q, input logic neg);
        return neg ? fp'(-q) : fp'(q);
    endfunction

endpackage

// File: rtl/vec3_normalize_seq_if.sv
// rtl/vec3_normalize_seq_if.sv - valid/ready input and output bundle of the normaliser
interface vec3_normalize_seq_if;
    import vec3_normalize_seq_pkg::*;

    logic        in_valid;
    logic        in_ready;
    vec3         in_vec;
    logic        out_valid;
    logic        out_ready;
    vec3         out_vec;
    logic [31:0] out_len;
    logic        out_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_len, out_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_len, out_zero
    );
endinterface

// File: rtl/vec3_normalize_seq_div.sv
// rtl/vec3_normalize_seq_div.sv - fp_div_seq: restoring unsigned divider, one quotient bit per cycle
module fp_div_seq #(
    parameter int DVD_W = 48,
    parameter int DIV_W = 32,
    parameter int Q_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Q_W-1:0]   quotient_o
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] dvd_q;
    logic [DVD_W-1:0] quo_q;
    logic [DIV_W-1:0] dsr_q;
    logic [DIV_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [DIV_W:0]   trial;
    logic             take;
    logic [DIV_W-1:0] rem_d;
    logic [DVD_W-1:0] quo_d;

    always_comb begin
        trial = {rem_q, dvd_q[DVD_W-1]};
        take  = trial >= {1'b0, dsr_q};
        rem_d = take ? DIV_W'(trial - {1'b0, dsr_q}) : DIV_W'(trial);
        quo_d = DVD_W'({quo_q, take});
    end

    // done_o marks the edge that retires the last bit; quotient_o is valid alongside it.
    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = Q_W'(quo_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i && !busy_q) begin
            dvd_q  <= dividend_i;
            dsr_q  <= divisor_i;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CNT_W'(DVD_W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vec3_normalize_seq.sv
// rtl/vec3_normalize_seq.sv - sequential Q16.16 vec3 normaliser: square, isqrt, three shared divides
module vec3_normalize_seq
    import vec3_normalize_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    vec3_normalize_seq_if.slave  bus
);
    norm_state_t state_q, state_d;

    vec3         vec_q;
    logic [63:0] rad_q;
    logic [35:0] rem_q;
    logic [31:0] root_q;
    logic [5:0]  cnt_q;
    logic [31:0] qx_q, qy_q;
    vec3         out_vec_q;
    logic [31:0] out_len_q;
    logic        out_zero_q;

    logic [31:0] mag_x, mag_y, mag_z;
    logic [63:0] sumsq;
    logic [35:0] sq_rem_sh, sq_trial, sq_rem_d;
    logic        sq_take;
    logic [31:0] sq_root_d;
    logic        sqrt_last;

    fp           cur_c;
    logic [47:0] div_dvd;
    logic        div_start, div_busy, div_done;
    logic [31:0] div_q;

    // Squarers are only consumed on the SQ edge.
    always_comb begin
        mag_x = abs_mag(vec_q.x);
        mag_y = abs_mag(vec_q.y);
        mag_z = abs_mag(vec_q.z);
        sumsq = {32'd0, mag_x} * {32'd0, mag_x}
              + {32'd0, mag_y} * {32'd0, mag_y}
              + {32'd0, mag_z} * {32'd0, mag_z};
    end

    // Restoring isqrt step: bring down two radicand bits, try (root<<2)|1.
    always_comb begin
        sq_rem_sh = 36'({rem_q, rad_q[63:62]});
        sq_trial  = {2'b00, root_q, 2'b01};
        sq_take   = sq_rem_sh >= sq_trial;
        sq_rem_d  = sq_take ? sq_rem_sh - sq_trial : sq_rem_sh;
        sq_root_d = {root_q[30:0], sq_take};
        sqrt_last = cnt_q == 6'd31;
    end

    always_comb begin
        case (state_q)
            DIVY:    cur_c = vec_q.y;
            DIVZ:    cur_c = vec_q.z;
            default: cur_c = vec_q.x;
        endcase
        div_dvd = {abs_mag(cur_c), 16'd0};
    end

    fp_div_seq #(
        .DVD_W (48),
        .DIV_W (32),
        .Q_W   (32)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (div_dvd),
        .divisor_i  (root_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SQ;
            SQ:      state_d = SQRT;
            SQRT:    if (sqrt_last) state_d = (sq_root_d == 32'd0) ? DONE : DIVX;
            DIVX:    if (div_done) state_d = DIVY;
            DIVY:    if (div_done) state_d = DIVZ;
            DIVZ:    if (div_done) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each divide state spends its first cycle loading the shared divider.
    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == DONE;
        div_start     = (state_q == DIVX || state_q == DIVY || state_q == DIVZ) && !div_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q      <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            out_vec_q  <= '0;
            out_len_q  <= '0;
            out_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) vec_q <= bus.in_vec;
                SQ: begin
                    rad_q  <= sumsq;
                    rem_q  <= '0;
                    root_q <= '0;
                    cnt_q  <= '0;
                end
                SQRT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= sq_rem_d;
                    root_q <= sq_root_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (sqrt_last && sq_root_d == 32'd0) begin
                        out_vec_q  <= '0;
                        out_len_q  <= '0;
                        out_zero_q <= 1'b1;
                    end
                end
                DIVX: if (div_done) qx_q <= div_q;
                DIVY: if (div_done) qy_q <= div_q;
                DIVZ: if (div_done) begin
                    out_vec_q.x <= apply_sign(qx_q, vec_q.x[31]);
                    out_vec_q.y <= apply_sign(qy_q, vec_q.y[31]);
                    out_vec_q.z <= apply_sign(div_q, vec_q.z[31]);
                    out_len_q   <= root_q;
                    out_zero_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_vec  = out_vec_q;
    assign bus.out_len  = out_len_q;
    assign bus.out_zero = out_zero_q;
endmodule
